// File: rtl/serial_sub16.sv
// -----------------------------------------------------------------------------
// serial_sub16 -- multi-cycle serial subtractor: diff = a - b - bin
//
// Processes DIGIT bits per clock, LSB first, with a registered borrow chained
// between digits. A start pulse in IDLE captures the operands. After
// N = WIDTH/DIGIT RUN cycles the result is written to the output registers
// and done pulses for one cycle. The results then hold until the next
// operation completes.
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the signed overflow output ovf)
//
// Parameters:
//   WIDTH  operand/result width (default 16)
//   DIGIT  bits processed per RUN cycle; must divide WIDTH evenly (default 1)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   a      in   minuend, captured on accepted start
//   b      in   subtrahend, captured on accepted start
//   bin    in   borrow-in, captured on accepted start
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, diff/bout valid
//   diff   out  a - b - bin mod 2^WIDTH
//   bout   out  borrow-out (a < b + bin, unsigned)
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
// -----------------------------------------------------------------------------
module serial_sub16 #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    // One digit of the subtraction; bit DIGIT of the result is the borrow out.
    logic [DIGIT:0]     dig_diff_s;
    logic [WIDTH-1:0]   res_shift_s;
    logic               last_s;

    // Digit datapath: subtract the low digit and shift it into the top of the result.
    always_comb begin
        dig_diff_s  = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]}
                    - {{DIGIT{1'b0}}, borrow_q};
        res_shift_s = res_q >> DIGIT;
        res_shift_s[WIDTH-1 -: DIGIT] = dig_diff_s[DIGIT-1:0];
        last_s      = (cnt_q == CNT_W'(N - 1));
    end

    // Next-state and datapath register updates for IDLE -> RUN -> DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = {CNT_W{1'b0}};
                    res_d    = {WIDTH{1'b0}};
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                borrow_d = dig_diff_s[DIGIT];
                res_d    = res_shift_s;
                if (last_s) begin
                    // Final digit: publish the complete result.
                    state_d = S_DONE;
                    cnt_d   = {CNT_W{1'b0}};
                    diff_d  = res_shift_s;
                    bout_d  = dig_diff_s[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (res_shift_s[WIDTH-1] != a_msb_q);
`endif
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they align with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            res_q    <= {WIDTH{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            bout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
